// File: rtl/shift_arbiter_if.sv
// Bus bundle for shift_arbiter: two requester ports, the shared shifter
// port, the response port and status outputs.
// slave  : the arbiter side.
// master : the environment side (requesters, shifter, consumer).
interface shift_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_data;
  logic [4:0]       req0_sel;
  logic             req0_rot;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_data;
  logic [4:0]       req1_sel;
  logic             req1_rot;

  logic [WIDTH-1:0] sh_in;
  logic [4:0]       sh_select;
  logic             sh_rotate;
  logic [WIDTH-1:0] sh_out;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_id;

  logic             busy;
  logic [15:0]      op_count;

  modport slave (
    input  req0_valid, req0_data, req0_sel, req0_rot,
    input  req1_valid, req1_data, req1_sel, req1_rot,
    input  sh_out, rsp_ready,
    output req0_ready, req1_ready,
    output sh_in, sh_select, sh_rotate,
    output rsp_valid, rsp_data, rsp_id, busy, op_count
  );

  modport master (
    output req0_valid, req0_data, req0_sel, req0_rot,
    output req1_valid, req1_data, req1_sel, req1_rot,
    output sh_out, rsp_ready,
    input  req0_ready, req1_ready,
    input  sh_in, sh_select, sh_rotate,
    input  rsp_valid, rsp_data, rsp_id, busy, op_count
  );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one right-shift/rotate unit between two
// requesters. One operation in flight at a time: IDLE -> ISSUE -> RESP.
// SH_LAT selects a combinational (0) or single-register (1) shifter.
module shift_arbiter #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned SH_LAT = 0
) (
  input logic            clk,
  input logic            rst_n,
  shift_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] opnd_data_q;
  logic [4:0]       opnd_sel_q;
  logic             opnd_rot_q;
  logic             owner_q;
  logic             last_grant_q;
  logic             issue_cnt_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_id_q;
  logic [15:0]      op_count_q;

  logic grant0;
  logic grant1;
  logic issue_last;

  // Grant: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    grant0 = bus.req0_valid && (!bus.req1_valid || last_grant_q);
    grant1 = bus.req1_valid && !grant0;
  end

  // Final ISSUE cycle is the one where the shifter result is valid.
  assign issue_last = (SH_LAT == 0) || issue_cnt_q;

  // Controller FSM and all datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      opnd_data_q  <= '0;
      opnd_sel_q   <= '0;
      opnd_rot_q   <= 1'b0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      issue_cnt_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= 1'b0;
      op_count_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          issue_cnt_q <= 1'b0;
          if (grant0) begin
            opnd_data_q <= bus.req0_data;
            opnd_sel_q  <= bus.req0_sel;
            opnd_rot_q  <= bus.req0_rot;
            owner_q     <= 1'b0;
            state_q     <= StIssue;
          end else if (grant1) begin
            opnd_data_q <= bus.req1_data;
            opnd_sel_q  <= bus.req1_sel;
            opnd_rot_q  <= bus.req1_rot;
            owner_q     <= 1'b1;
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          if (issue_last) begin
            rsp_data_q <= bus.sh_out;
            rsp_id_q   <= owner_q;
            state_q    <= StResp;
          end else begin
            issue_cnt_q <= 1'b1;
          end
        end
        StResp: begin
          if (bus.rsp_ready) begin
            last_grant_q <= owner_q;
            op_count_q   <= op_count_q + 16'd1;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Output decode: shifter port is quiet (zero) outside ISSUE.
  always_comb begin
    bus.req0_ready = (state_q == StIdle) && grant0;
    bus.req1_ready = (state_q == StIdle) && grant1;
    bus.sh_in      = (state_q == StIssue) ? opnd_data_q : '0;
    bus.sh_select  = (state_q == StIssue) ? opnd_sel_q : 5'd0;
    bus.sh_rotate  = (state_q == StIssue) && opnd_rot_q;
    bus.rsp_valid  = (state_q == StResp);
    bus.rsp_data   = rsp_data_q;
    bus.rsp_id     = rsp_id_q;
    bus.busy       = (state_q != StIdle);
    bus.op_count   = op_count_q;
  end

endmodule
